// File: rtl/adc_push_sequencer.sv
// Sample FIFO between the ADC capture logic and the correlator bank.
// Buffered samples go out as PushADC strobes at a bus-programmed cadence.
`timescale 1ns/1ps
module adc_push_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFE000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic [15:0] adc_in,
  input  logic        adc_in_valid,
  output logic        adc_in_ready,
  output logic [15:0] ADC,
  output logic        PushADC
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [31:0] A_CTRL    = BASE_ADDR;
  localparam logic [31:0] A_DIV     = BASE_ADDR + 32'h4;
  localparam logic [31:0] A_STATUS  = BASE_ADDR + 32'h8;
  localparam logic [31:0] A_PUSHCNT = BASE_ADDR + 32'hC;

  logic          enable_q, enable_d;
  logic          offset_q, offset_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [31:0]   pushcnt_q, pushcnt_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   adc_q, adc_d;
  logic          push_q, push_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic [LW-1:0] level;
  logic          empty, full;
  logic          wr_ctrl, wr_div, wr_status, wr_pcnt;
  logic          flush, tick, pop, push_in, ovf_set, unf_set;
  logic [15:0]   head;

  // Fill level and flags come from registered pointers only.
  assign level        = wr_ptr_q - rd_ptr_q;
  assign empty        = (level == '0);
  assign full         = (level == LW'(FIFO_DEPTH));
  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign adc_in_ready = !full;
  assign ADC          = adc_q;
  assign PushADC      = push_q;

  always_comb begin
    wr_ctrl   = write && (addr == A_CTRL);
    wr_div    = write && (addr == A_DIV);
    wr_status = write && (addr == A_STATUS);
    wr_pcnt   = write && (addr == A_PUSHCNT);
    flush     = wr_ctrl && Wdata[2];
    tick      = enable_q && (cnt_q == div_q);
    pop       = tick && !empty && !flush;
    push_in   = adc_in_valid && !full && !flush;
    ovf_set   = adc_in_valid && full && !flush;
    unf_set   = tick && empty;
  end

  always_comb begin
    enable_d  = enable_q;
    offset_d  = offset_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    pushcnt_d = pushcnt_q;
    wr_ptr_d  = wr_ptr_q + LW'(push_in);
    rd_ptr_d  = rd_ptr_q + LW'(pop);
    adc_d     = adc_q;
    push_d    = pop;

    if (wr_ctrl) begin
      enable_d = Wdata[0];
      offset_d = Wdata[1];
    end
    if (wr_div) div_d = Wdata[15:0];

    // Reprogramming the cadence restarts the interval from zero.
    if (wr_div || (wr_ctrl && (Wdata[0] != enable_q)) || !enable_q || tick)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;

    ovf_d = (ovf_q && !(wr_status && Wdata[8])) || ovf_set;
    unf_d = (unf_q && !(wr_status && Wdata[9])) || unf_set;

    if (wr_pcnt)     pushcnt_d = Wdata;
    else if (push_q) pushcnt_d = pushcnt_q + 32'd1;

    if (flush) rd_ptr_d = wr_ptr_q;
    if (pop)   adc_d = head ^ {offset_q, 15'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= 1'b0;
      offset_q  <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      pushcnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      adc_q     <= '0;
      push_q    <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      offset_q  <= offset_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      pushcnt_q <= pushcnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      adc_q     <= adc_d;
      push_q    <= push_d;
    end
  end

  // Sample storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push_in) mem_q[wr_ptr_q[AW-1:0]] <= adc_in;
  end

  always_comb begin
    Rdata = '0;
    if (rst && read) begin
      unique case (addr)
        A_CTRL:    Rdata = {30'b0, offset_q, enable_q};
        A_DIV:     Rdata = {16'b0, div_q};
        A_STATUS: begin
          Rdata[LW-1:0] = level;
          Rdata[8]      = ovf_q;
          Rdata[9]      = unf_q;
        end
        A_PUSHCNT: Rdata = pushcnt_q;
        default:   Rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_push_sequencer.sv
// Directed bench for adc_push_sequencer: cadence, FIFO limits, format, flush, reset.
`timescale 1ns/1ps
module tb_adc_push_sequencer;

  localparam logic [31:0] A_CTRL    = 32'hFE000000;
  localparam logic [31:0] A_DIV     = 32'hFE000004;
  localparam logic [31:0] A_STATUS  = 32'hFE000008;
  localparam logic [31:0] A_PUSHCNT = 32'hFE00000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] Wdata = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] Rdata;
  logic [15:0] adc_in = '0;
  logic        adc_in_valid = 1'b0;
  logic        adc_in_ready;
  logic [15:0] ADC;
  logic        PushADC;

  int total = 0;
  int bad = 0;

  adc_push_sequencer #(.FIFO_DEPTH(8), .BASE_ADDR(32'hFE000000)) dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
    .read(read), .Rdata(Rdata), .adc_in(adc_in), .adc_in_valid(adc_in_valid),
    .adc_in_ready(adc_in_ready), .ADC(ADC), .PushADC(PushADC)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; Wdata = d; write = 1'b1;
    cycle();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; read = 1'b1;
    #1;
    d = Rdata;
    read = 1'b0;
  endtask

  task automatic push_sample(input logic [15:0] v);
    adc_in = v; adc_in_valid = 1'b1;
    cycle();
    adc_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] regs [4];
    regs[0] = A_CTRL; regs[1] = A_DIV; regs[2] = A_STATUS; regs[3] = A_PUSHCNT;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      bus_read(regs[i], d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL reset_reg%0d got=%h exp=0", i, d); end
    end
    total++;
    if (adc_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", adc_in_ready); end
    total++;
    if (PushADC !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", PushADC); end
  endtask

  task automatic test_cadence();
    logic [31:0] d;
    logic exp_p;
    bus_write(A_DIV, 32'd3);
    for (int k = 1; k <= 5; k++) push_sample(16'(k));
    bus_write(A_CTRL, 32'h1);
    // Strobes land 4, 8, .. 20 cycles after enable; the 6th tick finds the FIFO empty.
    for (int i = 1; i <= 26; i++) begin
      cycle();
      exp_p = (i % 4 == 0) && (i <= 20);
      total++;
      if (PushADC !== exp_p) begin bad++; $display("FAIL cadence_push c%0d got=%b exp=%b", i, PushADC, exp_p); end
      if (exp_p) begin
        total++;
        if (ADC !== 16'(i / 4)) begin bad++; $display("FAIL cadence_adc c%0d got=%h exp=%h", i, ADC, 16'(i / 4)); end
      end
    end
    bus_write(A_CTRL, 32'h0);
    bus_read(A_PUSHCNT, d);
    total++;
    if (d !== 32'd5) begin bad++; $display("FAIL cadence_pushcnt got=%0d exp=5", d); end
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h200) begin bad++; $display("FAIL cadence_underrun got=%h exp=200", d); end
    bus_write(A_STATUS, 32'h300);
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL cadence_clear got=%h exp=0", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic exp_p;
    adc_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      adc_in = 16'h0010 + 16'(k);
      cycle();
    end
    adc_in_valid = 1'b0;
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h108) begin bad++; $display("FAIL ovf_status got=%h exp=108", d); end
    total++;
    if (adc_in_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b exp=0", adc_in_ready); end
    bus_write(A_STATUS, 32'h100);
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h008) begin bad++; $display("FAIL ovf_clear got=%h exp=008", d); end
    // Drain at full rate: only the first eight samples may come out.
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      exp_p = (i <= 8);
      total++;
      if (PushADC !== exp_p) begin bad++; $display("FAIL drain_push c%0d got=%b exp=%b", i, PushADC, exp_p); end
      if (exp_p) begin
        total++;
        if (ADC !== 16'h0010 + 16'(i - 1)) begin bad++; $display("FAIL drain_adc c%0d got=%h exp=%h", i, ADC, 16'h0010 + 16'(i - 1)); end
      end
    end
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h200) begin bad++; $display("FAIL drain_status got=%h exp=200", d); end
    bus_write(A_STATUS, 32'h300);
  endtask

  task automatic test_offset_binary();
    bus_write(A_CTRL, 32'h2);
    push_sample(16'h8000);
    push_sample(16'h7FFF);
    bus_write(A_CTRL, 32'h3);
    cycle();
    total++;
    if (PushADC !== 1'b1 || ADC !== 16'h0000) begin bad++; $display("FAIL offbin_8000 push=%b got=%h exp=0000", PushADC, ADC); end
    cycle();
    total++;
    if (PushADC !== 1'b1 || ADC !== 16'hFFFF) begin bad++; $display("FAIL offbin_7fff push=%b got=%h exp=ffff", PushADC, ADC); end
    bus_write(A_CTRL, 32'h0);
    total++;
    if (PushADC !== 1'b0 || ADC !== 16'hFFFF) begin bad++; $display("FAIL adc_hold push=%b got=%h exp=ffff", PushADC, ADC); end
    bus_write(A_STATUS, 32'h300);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int strobes = 0;
    bus_write(A_PUSHCNT, 32'h0);
    adc_in = 16'h0100; adc_in_valid = 1'b1;
    bus_write(A_CTRL, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      adc_in = 16'h0100 + 16'(i);
      cycle();
      if (PushADC === 1'b1) strobes++;
      total++;
      if (PushADC !== 1'b1 || ADC !== 16'h0100 + 16'(i - 1)) begin
        bad++; $display("FAIL b2b_push c%0d push=%b got=%h exp=%h", i, PushADC, ADC, 16'h0100 + 16'(i - 1));
      end
      bus_read(A_STATUS, d);
      total++;
      if (d !== 32'h001) begin bad++; $display("FAIL b2b_level c%0d got=%h exp=001", i, d); end
    end
    adc_in_valid = 1'b0;
    bus_write(A_CTRL, 32'h0);
    if (PushADC === 1'b1) strobes++;
    total++;
    if (PushADC !== 1'b1 || ADC !== 16'h0114) begin bad++; $display("FAIL b2b_last push=%b got=%h exp=0114", PushADC, ADC); end
    cycle();
    bus_read(A_PUSHCNT, d);
    total++;
    if (d !== 32'(strobes) || strobes != 21) begin bad++; $display("FAIL b2b_pushcnt got=%0d strobes=%0d exp=21", d, strobes); end
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL b2b_status got=%h exp=0", d); end
  endtask

  task automatic test_flush_and_reset();
    logic [31:0] d;
    logic [31:0] regs [4];
    regs[0] = A_CTRL; regs[1] = A_DIV; regs[2] = A_STATUS; regs[3] = A_PUSHCNT;
    for (int k = 0; k < 4; k++) push_sample(16'h0040 + 16'(k));
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h004) begin bad++; $display("FAIL flush_pre got=%h exp=004", d); end
    bus_write(A_CTRL, 32'h1);
    // Flush coincides with a tick and an incoming sample.
    adc_in = 16'h0099; adc_in_valid = 1'b1;
    bus_write(A_CTRL, 32'h5);
    adc_in_valid = 1'b0;
    total++;
    if (PushADC !== 1'b0) begin bad++; $display("FAIL flush_pop_cancel got=%b exp=0", PushADC); end
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL flush_status got=%h exp=0", d); end
    cycle();
    total++;
    if (PushADC !== 1'b0) begin bad++; $display("FAIL flush_nostrobe got=%b exp=0", PushADC); end
    bus_read(A_STATUS, d);
    total++;
    if (d !== 32'h200) begin bad++; $display("FAIL flush_underrun got=%h exp=200", d); end

    adc_in = 16'h0055; adc_in_valid = 1'b1;
    cycle();
    cycle();
    total++;
    if (PushADC !== 1'b1 || ADC !== 16'h0055) begin bad++; $display("FAIL rst_active push=%b got=%h exp=0055", PushADC, ADC); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (PushADC !== 1'b0 || ADC !== 16'h0 || adc_in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_async push=%b adc=%h ready=%b exp=0/0000/1", PushADC, ADC, adc_in_ready);
    end
    bus_read(A_PUSHCNT, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", d); end
    adc_in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      bus_read(regs[i], d);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL rst_reg%0d got=%h exp=0", i, d); end
    end
    total++;
    if (PushADC !== 1'b0 || adc_in_ready !== 1'b1) begin bad++; $display("FAIL rst_after push=%b ready=%b exp=0/1", PushADC, adc_in_ready); end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_overflow();
    test_offset_binary();
    test_back_to_back();
    test_flush_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
